// File: rtl/muxn_arb_pkg.sv
// Shared types and defaults for the N-way mux with explicit-select / round-robin arbitration.
package muxn_pkg;

    typedef enum logic {
        MODE_SEL = 1'b0,
        MODE_RR  = 1'b1
    } mode_e;

    localparam int DEF_WIDTH  = 16;
    localparam int DEF_NUM_IN = 4;

    // Select/pointer width; never narrower than one bit.
    function automatic int sel_w(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/muxn_arb_if.sv
// Handshake and data bundle between the channel sources, the mux and the downstream sink.
interface muxn_arb_if
    import muxn_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int NUM_IN = DEF_NUM_IN
) ();
    localparam int SEL_W = sel_w(NUM_IN);

    logic                    mode;
    logic [SEL_W-1:0]        sel;
    logic [NUM_IN-1:0]       in_valid;
    logic [NUM_IN-1:0]       in_ready;
    logic [NUM_IN*WIDTH-1:0] d_in;
    logic                    out_valid;
    logic                    out_ready;
    logic [WIDTH-1:0]        d_out;
    logic [SEL_W-1:0]        d_src;

    modport master (
        output mode, sel, in_valid, d_in, out_ready,
        input  in_ready, out_valid, d_out, d_src
    );

    modport slave (
        input  mode, sel, in_valid, d_in, out_ready,
        output in_ready, out_valid, d_out, d_src
    );
endinterface

// File: rtl/muxn_arb_rr_arbiter.sv
// Round-robin search: first requester at or above ptr, wrapping modulo NUM_IN,
// plus the pointer value that follows a grant.
module rr_arbiter
    import muxn_pkg::*;
#(
    parameter int NUM_IN = DEF_NUM_IN,
    parameter int SEL_W  = sel_w(NUM_IN)
) (
    input  logic [NUM_IN-1:0] req,
    input  logic [SEL_W-1:0]  ptr,
    input  logic              en,
    output logic [NUM_IN-1:0] gnt,
    output logic [SEL_W-1:0]  idx,
    output logic              gnt_vld,
    output logic [SEL_W-1:0]  ptr_nxt
);
    logic found;
    int   c;

    // Rotating priority search starting at ptr.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        c     = 0;
        for (int k = 0; k < NUM_IN; k++) begin
            c = int'(ptr) + k;
            if (c >= NUM_IN) c = c - NUM_IN;
            if (!found && req[c[SEL_W-1:0]]) begin
                found = 1'b1;
                idx   = c[SEL_W-1:0];
            end
        end
    end

    // One-hot grant and next pointer; explicit wrap keeps non-power-of-two counts correct.
    always_comb begin
        gnt_vld = en && found;
        gnt     = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            gnt[i] = gnt_vld && (idx == SEL_W'(i));
        end
        ptr_nxt = (idx == SEL_W'(NUM_IN - 1)) ? '0 : idx + 1'b1;
    end

endmodule

// File: rtl/muxn_arb.sv
// N-input mux with a single output register; channel chosen by SEL or by round-robin.
module muxn_arb
    import muxn_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int NUM_IN = DEF_NUM_IN
) (
    input logic       clk,
    input logic       rst_n,
    muxn_arb_if.slave bus
);
    localparam int SEL_W = sel_w(NUM_IN);

    mode_e             mode;
    logic              ld;
    logic              sel_ok;
    logic              rr_en;
    logic [NUM_IN-1:0] rr_gnt;
    logic [SEL_W-1:0]  rr_idx;
    logic              rr_vld;
    logic [SEL_W-1:0]  ptr_nxt;
    logic [SEL_W-1:0]  ptr;
    logic [NUM_IN-1:0] gnt;
    logic [SEL_W-1:0]  gnt_idx;
    logic              gnt_vld;
    logic [WIDTH-1:0]  d_sel;

    logic              vld_p1;
    logic [WIDTH-1:0]  d_p1;
    logic [SEL_W-1:0]  src_p1;

    assign mode = mode_e'(bus.mode);

    // Register can accept when empty or draining; nothing is granted while in reset.
    assign ld     = rst_n && (!vld_p1 || bus.out_ready);
    assign sel_ok = int'(bus.sel) < NUM_IN;
    assign rr_en  = ld && (mode == MODE_RR);

    rr_arbiter #(
        .NUM_IN (NUM_IN),
        .SEL_W  (SEL_W)
    ) u_rr (
        .req     (bus.in_valid),
        .ptr     (ptr),
        .en      (rr_en),
        .gnt     (rr_gnt),
        .idx     (rr_idx),
        .gnt_vld (rr_vld),
        .ptr_nxt (ptr_nxt)
    );

    // Grant selection: round-robin result or the explicitly selected channel.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_vld = 1'b0;
        if (mode == MODE_RR) begin
            gnt     = rr_gnt;
            gnt_idx = rr_idx;
            gnt_vld = rr_vld;
        end else if (ld && sel_ok) begin
            if (bus.in_valid[bus.sel]) begin
                gnt[bus.sel] = 1'b1;
                gnt_idx      = bus.sel;
                gnt_vld      = 1'b1;
            end
        end
    end

    // One-hot data mux driven by the grant.
    always_comb begin
        d_sel = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (gnt[i]) d_sel = bus.d_in[i*WIDTH +: WIDTH];
        end
    end

    assign bus.in_ready = gnt;

    // Round-robin pointer moves past the winner; holds otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      ptr <= '0;
        else if (rr_vld) ptr <= ptr_nxt;
    end

    // ---- stage p1: output register ----
    // Occupancy: refilled or cleared whenever the register may load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)  vld_p1 <= 1'b0;
        else if (ld) vld_p1 <= gnt_vld;
    end

    // Output word: captures granted channel data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       d_p1 <= '0;
        else if (gnt_vld) d_p1 <= d_sel;
    end

    // Source index travels with the word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       src_p1 <= '0;
        else if (gnt_vld) src_p1 <= gnt_idx;
    end

    assign bus.out_valid = vld_p1;
    assign bus.d_out     = d_p1;
    assign bus.d_src     = src_p1;

endmodule

// File: tb/tb_muxn_arb.sv
// Directed bench for muxn_arb: 4-channel instance plus a 3-channel instance for wrap/range cases.
module tb_muxn_arb;
    import muxn_pkg::*;

    logic clk;
    logic rst_n;
    int   vectors;
    int   errs;

    muxn_arb_if #(.WIDTH(16), .NUM_IN(4)) bus4 ();
    muxn_arb_if #(.WIDTH(16), .NUM_IN(3)) bus3 ();

    muxn_arb #(.WIDTH(16), .NUM_IN(4)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4.slave)
    );

    muxn_arb #(.WIDTH(16), .NUM_IN(3)) dut3 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus3.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic rdy4(input string tag, input logic [3:0] r);
        chk({tag, ".rdy"}, 32'(bus4.in_ready), 32'(r));
    endtask

    task automatic out4(input string tag, input logic v, input logic [15:0] d, input logic [1:0] s);
        chk({tag, ".vld"}, 32'(bus4.out_valid), 32'(v));
        chk({tag, ".d"},   32'(bus4.d_out),     32'(d));
        chk({tag, ".src"}, 32'(bus4.d_src),     32'(s));
    endtask

    task automatic rdy3(input string tag, input logic [2:0] r);
        chk({tag, ".rdy3"}, 32'(bus3.in_ready), 32'(r));
    endtask

    task automatic out3(input string tag, input logic v, input logic [15:0] d, input logic [1:0] s);
        chk({tag, ".vld3"}, 32'(bus3.out_valid), 32'(v));
        chk({tag, ".d3"},   32'(bus3.d_out),     32'(d));
        chk({tag, ".src3"}, 32'(bus3.d_src),     32'(s));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vectors = 0;
        errs    = 0;
        rst_n   = 1'b0;

        bus4.mode      = MODE_RR;
        bus4.sel       = '0;
        bus4.in_valid  = 4'b1111;
        bus4.out_ready = 1'b1;
        bus4.d_in      = {16'hD3D3, 16'hC2C2, 16'hB1B1, 16'hA0A0};

        bus3.mode      = MODE_SEL;
        bus3.sel       = '0;
        bus3.in_valid  = '0;
        bus3.out_ready = 1'b1;
        bus3.d_in      = {16'h0C0C, 16'h0B0B, 16'h0A0A};

        // Reset state with requests present
        tick();
        rdy4("rst", 4'b0000);
        out4("rst", 1'b0, 16'h0000, 2'd0);
        out3("rst", 1'b0, 16'h0000, 2'd0);

        // Round-robin from reset, all channels valid
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        rdy4("rr0", 4'b0001);
        tick(); out4("rr0", 1'b1, 16'hA0A0, 2'd0); rdy4("rr1", 4'b0010);
        tick(); out4("rr1", 1'b1, 16'hB1B1, 2'd1); rdy4("rr2", 4'b0100);
        tick(); out4("rr2", 1'b1, 16'hC2C2, 2'd2); rdy4("rr3", 4'b1000);
        tick(); out4("rr3", 1'b1, 16'hD3D3, 2'd3); rdy4("rr4", 4'b0001);
        tick(); out4("rr4", 1'b1, 16'hA0A0, 2'd0);

        // Move pointer to 2, then sparse requests 1010
        bus4.in_valid = 4'b0010;
        #1; rdy4("sp0", 4'b0010);
        tick(); out4("sp0", 1'b1, 16'hB1B1, 2'd1);
        bus4.in_valid = 4'b1010;
        #1; rdy4("sp1", 4'b1000);
        tick(); out4("sp1", 1'b1, 16'hD3D3, 2'd3); rdy4("sp2", 4'b0010);
        tick(); out4("sp2", 1'b1, 16'hB1B1, 2'd1); rdy4("sp3", 4'b1000);

        // Drain with no grant empties the register
        bus4.in_valid = 4'b0000;
        #1; rdy4("drain", 4'b0000);
        tick(); chk("drain.vld", 32'(bus4.out_valid), 32'd0);

        // Explicit select of channel 2
        bus4.mode     = MODE_SEL;
        bus4.sel      = 2'd2;
        bus4.in_valid = 4'b0100;
        bus4.d_in     = {16'hD3D3, 16'h0011, 16'h1111, 16'h1234};
        #1; rdy4("sel2", 4'b0100);
        tick(); out4("sel2", 1'b1, 16'h0011, 2'd2);

        // Load 16'h1234 then stall three cycles
        bus4.sel      = 2'd0;
        bus4.in_valid = 4'b0001;
        #1; rdy4("sel0", 4'b0001);
        tick(); out4("sel0", 1'b1, 16'h1234, 2'd0);
        bus4.out_ready = 1'b0;
        bus4.sel       = 2'd1;
        bus4.in_valid  = 4'b0011;
        #1; rdy4("stall", 4'b0000);
        for (int i = 0; i < 3; i++) begin
            tick();
            out4("stall", 1'b1, 16'h1234, 2'd0);
            rdy4("stall", 4'b0000);
        end
        bus4.out_ready = 1'b1;
        #1; rdy4("unstall", 4'b0010);
        tick(); out4("unstall", 1'b1, 16'h1111, 2'd1);

        // Mode switch while stalled; pointer held at 2 during explicit mode
        bus4.mode      = MODE_RR;
        bus4.out_ready = 1'b0;
        bus4.in_valid  = 4'b1111;
        #1; rdy4("msw0", 4'b0000);
        tick(); out4("msw0", 1'b1, 16'h1111, 2'd1);
        bus4.out_ready = 1'b1;
        #1; rdy4("msw1", 4'b0100);
        tick(); out4("msw1", 1'b1, 16'h0011, 2'd2);
        bus4.mode = MODE_SEL;
        bus4.sel  = 2'd0;
        #1; rdy4("msw2", 4'b0001);
        tick(); out4("msw2", 1'b1, 16'h1234, 2'd0);

        // Asynchronous reset mid-transfer
        #2 rst_n = 1'b0;
        #1;
        out4("arst", 1'b0, 16'h0000, 2'd0);
        rdy4("arst", 4'b0000);
        @(posedge clk);
        @(negedge clk);
        bus4.mode      = MODE_RR;
        bus4.in_valid  = 4'b1010;
        bus4.out_ready = 1'b0;
        rst_n = 1'b1;
        #1; rdy4("post", 4'b0010);
        tick(); out4("post", 1'b1, 16'h1111, 2'd1); rdy4("post_full", 4'b0000);

        // Three-channel instance: out-of-range select, then wrap
        bus3.mode     = MODE_SEL;
        bus3.sel      = 2'd3;
        bus3.in_valid = 3'b111;
        #1; rdy3("oor", 3'b000);
        tick(); chk("oor.vld3a", 32'(bus3.out_valid), 32'd0);
        tick(); chk("oor.vld3b", 32'(bus3.out_valid), 32'd0);
        bus3.sel = 2'd2;
        #1; rdy3("s3", 3'b100);
        tick(); out3("s3", 1'b1, 16'h0C0C, 2'd2);
        bus3.mode = MODE_RR;
        #1; rdy3("w0", 3'b001);
        tick(); out3("w0", 1'b1, 16'h0A0A, 2'd0); rdy3("w1", 3'b010);
        tick(); out3("w1", 1'b1, 16'h0B0B, 2'd1); rdy3("w2", 3'b100);
        tick(); out3("w2", 1'b1, 16'h0C0C, 2'd2); rdy3("w3", 3'b001);
        tick(); out3("w3", 1'b1, 16'h0A0A, 2'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
